value_change_monitor: RTL

Synthesizable observer for a three-register value stream (x, y, z). It samples the three words every clock, detects any change, and pushes a timestamped record into an internal FIFO. A downstream reader drains the FIFO over a valid/ready handshake. It is the consuming end of the labK stimulus sequence: the hardware counterpart of a print-on-change monitor, placed beside any block that drives x/y/z.

---
 rtl/value_change_monitor.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/value_change_monitor.sv
// ---------------------------------------------------------------------------
// value_change_monitor
//
// Watches three words (x, y, z) at every rising clock edge. When sampling is
// enabled and any word differs from the previous sample, or it is the first
// sample after reset, a record {ts, x, y, z} is pushed into a small
// first-word-fall-through FIFO. A downstream reader drains the FIFO with a
// valid/ready handshake.
//
// Optional feature macro: MON_DROP_COUNT_EN
//   defined   : drop_cnt is an 8-bit saturating count of dropped records
//   undefined : counter logic is compiled out, drop_cnt is tied to zero
//
// Parameters
//   W      width of each observed word
//   TS_W   width of the free-running cycle timestamp
//   DEPTH  FIFO entries (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mon_en     sampling enable (the timestamp runs regardless)
//   x, y, z    observed words
//   rec_valid  head record available
//   rec_ready  reader accepts the head record
//   rec_ts     timestamp of the head record
//   rec_x/y/z  captured words of the head record
//   ovf        sticky flag: at least one record was dropped
//   ovf_clr    clears ovf and drop_cnt (a same-cycle drop takes priority)
//   drop_cnt   saturating dropped-record count
// ---------------------------------------------------------------------------
module value_change_monitor #(
    parameter int W     = 32,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mon_en,
    input  logic [W-1:0]    x,
    input  logic [W-1:0]    y,
    input  logic [W-1:0]    z,
    output logic            rec_valid,
    input  logic            rec_ready,
    output logic [TS_W-1:0] rec_ts,
    output logic [W-1:0]    rec_x,
    output logic [W-1:0]    rec_y,
    output logic [W-1:0]    rec_z,
    output logic            ovf,
    input  logic            ovf_clr,
    output logic [7:0]      drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int REC_W = TS_W + 3 * W;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [TS_W-1:0]  ts_r;
    logic [W-1:0]     prev_x_r;
    logic [W-1:0]     prev_y_r;
    logic [W-1:0]     prev_z_r;
    logic             first_r;

    logic [REC_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             rec_valid_r;
    logic [REC_W-1:0] head_r;
    logic             ovf_r;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic             change_s;
    logic             push_req_s;
    logic             pop_s;
    logic             full_s;
    logic             drop_s;
    logic             push_s;
    logic [REC_W-1:0] push_data_s;
    logic [AW-1:0]    rd_ptr_next_s;
    logic [CW-1:0]    count_next_s;
    logic [REC_W-1:0] head_next_s;

    // Change detection, handshake decode and drop decision
    always_comb begin
        change_s    = first_r
                    || (x != prev_x_r)
                    || (y != prev_y_r)
                    || (z != prev_z_r);
        push_req_s  = mon_en && change_s;
        pop_s       = rec_valid_r && rec_ready;
        full_s      = (count_r == CW'(DEPTH));
        // A pop in the same cycle frees the slot, so only a full FIFO with
        // no pop loses the incoming record.
        drop_s      = push_req_s && full_s && !pop_s;
        push_s      = push_req_s && !drop_s;
        push_data_s = {ts_r, x, y, z};
    end

    // Next read pointer and occupancy
    always_comb begin
        rd_ptr_next_s = rd_ptr_r;
        count_next_s  = count_r;
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Next head record: the output registers always hold what the FIFO head
    // will be after this edge. When the new head is the slot being written
    // right now, the write data is forwarded because the array is not yet
    // updated. An empty FIFO keeps the last payload.
    always_comb begin
        head_next_s = head_r;
        if (count_next_s == CW'(1'b0)) begin
            head_next_s = head_r;
        end else if (push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // -----------------------------------------------------------------------
    // Sequential logic
    // -----------------------------------------------------------------------

    // Free-running timestamp, wraps naturally at 2^TS_W
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1'b1);
        end
    end

    // Previous-sample registers and first-sample flag, frozen while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_x_r <= {W{1'b0}};
            prev_y_r <= {W{1'b0}};
            prev_z_r <= {W{1'b0}};
            first_r  <= 1'b1;
        end else if (mon_en) begin
            prev_x_r <= x;
            prev_y_r <= y;
            prev_z_r <= z;
            first_r  <= 1'b0;
        end
    end

    // Record storage array; contents are only read once written, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data_s;
        end
    end

    // FIFO pointers, occupancy and registered head/valid outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            rec_valid_r <= 1'b0;
            head_r      <= {REC_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            rec_valid_r <= (count_next_s != CW'(1'b0));
            head_r      <= head_next_s;
        end
    end

    // Sticky overflow flag; a drop outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end
    end

`ifdef MON_DROP_COUNT_EN
    logic [7:0] drop_cnt_r;

    // Saturating drop counter; a drop in the clear cycle restarts it at one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s) begin
            if (ovf_clr) begin
                drop_cnt_r <= 8'd1;
            end else if (drop_cnt_r != 8'd255) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt_r <= 8'd0;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 8'd0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign rec_valid = rec_valid_r;
    assign rec_ts    = head_r[REC_W-1 -: TS_W];
    assign rec_x     = head_r[3*W-1 -: W];
    assign rec_y     = head_r[2*W-1 -: W];
    assign rec_z     = head_r[W-1:0];
    assign ovf       = ovf_r;

endmodule
